// File: rtl/csr_port_arb.sv
// csr_port_arb: arbitrates the csr_reg access port between the execute stage and the clint,
// with a clint lock for atomic sequences, a guaranteed ex slot after release, and a lock watchdog.
module csr_port_arb #(
  parameter int CSR_AW   = 32,
  parameter int CSR_DW   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ex_req_i,
  input  logic              ex_we_i,
  input  logic [CSR_AW-1:0] ex_addr_i,
  input  logic [CSR_DW-1:0] ex_wdata_i,
  output logic              ex_gnt_o,
  output logic [CSR_DW-1:0] ex_rdata_o,
  input  logic              int_req_i,
  input  logic              int_lock_i,
  input  logic              int_we_i,
  input  logic [CSR_AW-1:0] int_addr_i,
  input  logic [CSR_DW-1:0] int_wdata_i,
  output logic              int_gnt_o,
  output logic [CSR_DW-1:0] int_rdata_o,
  output logic [CSR_AW-1:0] csr_raddr_o,
  input  logic [CSR_DW-1:0] csr_rdata_i,
  output logic              csr_we_o,
  output logic [CSR_AW-1:0] csr_waddr_o,
  output logic [CSR_DW-1:0] csr_wdata_o,
  output logic              stall_o,
  output logic              lock_err_o
);
  localparam int CW = $clog2(LOCK_MAX) + 1;
  typedef enum logic [1:0] {IDLE, INT_LOCK, EX_SLOT} state_t;
  state_t        state;
  logic [CW-1:0] lock_cnt;
  logic          ex_blocked;
  logic          inhibit;
  logic          ex_pend;
  logic          wd_hit;
  always_comb begin
    int_gnt_o = (state == EX_SLOT) ? int_req_i & ~ex_req_i : int_req_i;
    ex_gnt_o  = (state == INT_LOCK) ? 1'b0 : (state == EX_SLOT) ? ex_req_i : ex_req_i & ~int_req_i;
  end
  assign ex_pend     = ex_blocked | ex_req_i;
  assign wd_hit      = lock_cnt >= CW'(LOCK_MAX - 1);
  assign csr_raddr_o = int_gnt_o ? int_addr_i : ex_gnt_o ? ex_addr_i : '0;
  assign csr_waddr_o = csr_raddr_o;
  assign csr_wdata_o = int_gnt_o ? int_wdata_i : ex_gnt_o ? ex_wdata_i : '0;
  assign csr_we_o    = (int_gnt_o & int_we_i) | (ex_gnt_o & ex_we_i);
  assign ex_rdata_o  = ex_gnt_o ? csr_rdata_i : '0;
  assign int_rdata_o = int_gnt_o ? csr_rdata_i : '0;
  assign stall_o     = ex_req_i & ~ex_gnt_o;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      lock_cnt   <= '0;
      ex_blocked <= 1'b0;
      inhibit    <= 1'b0;
      lock_err_o <= 1'b0;
    end else begin
      lock_err_o <= 1'b0;
      if (!int_lock_i) inhibit <= 1'b0;
      case (state)
        IDLE: begin
          ex_blocked <= ex_req_i & int_req_i;
          if (int_req_i & int_lock_i & ~inhibit) state <= INT_LOCK;
        end
        INT_LOCK: begin
          ex_blocked <= ex_pend;
          lock_cnt   <= (lock_cnt == CW'(LOCK_MAX)) ? lock_cnt : lock_cnt + 1'b1;
          if (!int_lock_i || wd_hit) begin
            state    <= ex_pend ? EX_SLOT : IDLE;
            lock_cnt <= '0;
            if (int_lock_i) begin
              lock_err_o <= 1'b1;
              inhibit    <= 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          ex_blocked <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_csr_port_arb.sv
// tb_csr_port_arb: directed checks of csr_port_arb with a small csr_reg model on the port.
module tb_csr_port_arb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_req = 1'b0, ex_we = 1'b0, int_req = 1'b0, int_lock = 1'b0, int_we = 1'b0;
  logic [31:0] ex_addr = '0, ex_wdata = '0, int_addr = '0, int_wdata = '0;
  logic        ex_gnt, int_gnt, csr_we, stall, lock_err;
  logic [31:0] ex_rdata, int_rdata, csr_raddr, csr_rdata, csr_waddr, csr_wdata;
  logic [31:0] mem [0:255];
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  assign csr_rdata = mem[csr_raddr[7:0]];
  always @(posedge clk) if (csr_we) mem[csr_waddr[7:0]] <= csr_wdata;
  csr_port_arb dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .ex_req_i(ex_req), .ex_we_i(ex_we), .ex_addr_i(ex_addr), .ex_wdata_i(ex_wdata),
    .ex_gnt_o(ex_gnt), .ex_rdata_o(ex_rdata),
    .int_req_i(int_req), .int_lock_i(int_lock), .int_we_i(int_we), .int_addr_i(int_addr),
    .int_wdata_i(int_wdata), .int_gnt_o(int_gnt), .int_rdata_o(int_rdata),
    .csr_raddr_o(csr_raddr), .csr_rdata_i(csr_rdata), .csr_we_o(csr_we),
    .csr_waddr_o(csr_waddr), .csr_wdata_o(csr_wdata), .stall_o(stall), .lock_err_o(lock_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic er, input logic ew, input logic [31:0] ea, input logic [31:0] ed,
                      input logic ir, input logic il, input logic iw, input logic [31:0] ia,
                      input logic [31:0] id);
    @(posedge clk);
    #2;
    {ex_req, ex_we, ex_addr, ex_wdata} = {er, ew, ea, ed};
    {int_req, int_lock, int_we, int_addr, int_wdata} = {ir, il, iw, ia, id};
    #1;
  endtask
  task automatic grants(input string tag, input logic eg, input logic ig, input logic st);
    chk({tag, "_ex_gnt"}, 32'(ex_gnt), 32'(eg));
    chk({tag, "_int_gnt"}, 32'(int_gnt), 32'(ig));
    chk({tag, "_stall"}, 32'(stall), 32'(st));
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    #3;
    grants("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_we", 32'(csr_we), 32'd0);
    chk("rst_lock_err", 32'(lock_err), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(1, 1, 32'h300, 32'h8, 0, 0, 0, 0, 0);
    grants("exw", 1'b1, 1'b0, 1'b0);
    chk("exw_we", 32'(csr_we), 32'd1);
    chk("exw_waddr", csr_waddr, 32'h300);
    chk("exw_wdata", csr_wdata, 32'h8);
    step(1, 0, 32'h341, 0, 1, 0, 1, 32'h341, 32'h1000);
    grants("coll", 1'b0, 1'b1, 1'b1);
    chk("coll_we", 32'(csr_we), 32'd1);
    chk("coll_wdata", csr_wdata, 32'h1000);
    step(1, 0, 32'h341, 0, 0, 0, 0, 0, 0);
    grants("exrd", 1'b1, 1'b0, 1'b0);
    chk("exrd_rdata", ex_rdata, 32'h1000);
    chk("exrd_int_rdata", int_rdata, 32'h0);
    chk("exrd_we", 32'(csr_we), 32'd0);
    step(1, 0, 32'h300, 0, 1, 1, 1, 32'h341, 32'hA);
    grants("b1", 1'b0, 1'b1, 1'b1);
    step(1, 0, 32'h300, 0, 1, 1, 1, 32'h342, 32'hB);
    grants("b2", 1'b0, 1'b1, 1'b1);
    chk("b2_waddr", csr_waddr, 32'h342);
    step(1, 0, 32'h300, 0, 1, 0, 1, 32'h300, 32'hC);
    grants("b3", 1'b0, 1'b1, 1'b1);
    step(1, 0, 32'h300, 0, 1, 0, 1, 32'h341, 32'hD);
    grants("b4", 1'b1, 1'b0, 1'b0);
    chk("b4_rdata", ex_rdata, 32'hC);
    chk("b4_we", 32'(csr_we), 32'd0);
    step(0, 0, 0, 0, 1, 0, 0, 32'h341, 0);
    grants("b5", 1'b0, 1'b1, 1'b0);
    chk("b5_int_rdata", int_rdata, 32'hA);
    step(1, 0, 32'h300, 0, 1, 1, 0, 32'h341, 0);
    grants("wd_entry", 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 32'h300, 0, 1, 1, 0, 32'h341, 0);
      grants($sformatf("wd_lock%0d", i), 1'b0, 1'b1, 1'b1);
      chk($sformatf("wd_err%0d", i), 32'(lock_err), 32'd0);
    end
    step(1, 0, 32'h300, 0, 1, 1, 0, 32'h341, 0);
    grants("wd_slot", 1'b1, 1'b0, 1'b0);
    chk("wd_err_pulse", 32'(lock_err), 32'd1);
    step(1, 0, 32'h300, 0, 1, 1, 0, 32'h341, 0);
    grants("inh1", 1'b0, 1'b1, 1'b1);
    chk("inh1_err", 32'(lock_err), 32'd0);
    step(0, 0, 0, 0, 1, 1, 0, 32'h341, 0);
    grants("inh2", 1'b0, 1'b1, 1'b0);
    step(1, 0, 32'h300, 0, 0, 1, 0, 0, 0);
    grants("inh3", 1'b1, 1'b0, 1'b0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    grants("inh_clr", 1'b0, 1'b0, 1'b0);
    step(0, 0, 0, 0, 1, 1, 0, 32'h341, 0);
    grants("relock1", 1'b0, 1'b1, 1'b0);
    step(1, 0, 32'h300, 0, 0, 1, 0, 0, 0);
    grants("relock2", 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    grants("midrst", 1'b1, 1'b0, 1'b0);
    chk("midrst_err", 32'(lock_err), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(1, 0, 32'h300, 0, 0, 0, 0, 0, 0);
    grants("postrst", 1'b1, 1'b0, 1'b0);
    chk("postrst_rdata", ex_rdata, 32'hC);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      grants($sformatf("idle%0d", i), 1'b0, 1'b0, 1'b0);
      chk($sformatf("idle%0d_we", i), 32'(csr_we), 32'd0);
      chk($sformatf("idle%0d_raddr", i), csr_raddr, 32'd0);
      chk($sformatf("idle%0d_wdata", i), csr_wdata, 32'd0);
      chk($sformatf("idle%0d_ex_rdata", i), ex_rdata, 32'd0);
      chk($sformatf("idle%0d_int_rdata", i), int_rdata, 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/csr_port_arb.md
Name: csr_port_arb

Overview:
- Arbitrates the single CSR register-file access port between two requesters:
  - the execute stage (CSR instructions);
  - the clint (interrupt entry/exit sequences, which write mepc/mcause/mstatus back-to-back).
- Supports a clint lock for atomic multi-cycle sequences.
- Guarantees the execute stage one slot after every lock release.
- Bounds lock duration with a watchdog.
- Sits between id_ex/ex, clint and csr_reg.

Parameters:
- CSR_AW, 32, CSR address width.
- CSR_DW, 32, CSR data width.
- LOCK_MAX, 16, maximum consecutive cycles in INT_LOCK before forced release (>=2).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- ex_req_i  in  1  execute stage requests the CSR port this cycle.
- ex_we_i  in  1  execute access is a write.
- ex_addr_i  in  CSR_AW  execute CSR address (read and write).
- ex_wdata_i  in  CSR_DW  execute write data.
- ex_gnt_o  out  1  execute access performed this cycle.
- ex_rdata_o  out  CSR_DW  csr_rdata_i when ex_gnt_o, else 0.
- int_req_i  in  1  clint requests the CSR port.
- int_lock_i  in  1  clint wants to keep ownership after this cycle.
- int_we_i  in  1  clint access is a write.
- int_addr_i  in  CSR_AW  clint CSR address.
- int_wdata_i  in  CSR_DW  clint write data.
- int_gnt_o  out  1  clint access performed this cycle.
- int_rdata_o  out  CSR_DW  csr_rdata_i when int_gnt_o, else 0.
- csr_raddr_o  out  CSR_AW  to csr_reg read address.
- csr_rdata_i  in  CSR_DW  csr_reg combinational read data.
- csr_we_o  out  1  csr_reg write enable.
- csr_waddr_o  out  CSR_AW  csr_reg write address.
- csr_wdata_o  out  CSR_DW  csr_reg write data.
- stall_o  out  1  ex_req_i & ~ex_gnt_o; holds the pipeline.
- lock_err_o  out  1  registered one-cycle pulse on watchdog expiry.

Behaviour:
- Grants are combinational from registered state and current requests. At most one grant per cycle.
- Port mux:
  - The granted side drives csr_raddr_o, csr_waddr_o, csr_wdata_o and csr_we_o (= granted we).
  - With no grant, all csr_* outputs and both rdata outputs are 0.
- Reset (async, rst_n_i=0): state=IDLE, lock_cnt=0, ex_blocked=0, inhibit=0, lock_err_o=0. Grants then follow IDLE rules from the inputs.
- FSM states: IDLE, INT_LOCK, EX_SLOT.
- IDLE:
  - int_req_i has priority: int_gnt_o=1 and ex_gnt_o=0. Next state is INT_LOCK if int_lock_i & ~inhibit, else IDLE.
  - Otherwise ex_gnt_o=ex_req_i.
  - ex_blocked <= ex_req_i & int_req_i.
- INT_LOCK:
  - int_gnt_o=int_req_i, ex_gnt_o=0. Idle cycles with the lock held are allowed.
  - lock_cnt increments every cycle, saturating.
  - ex_blocked |= ex_req_i.
  - Exit when int_lock_i=0: next EX_SLOT if ex_blocked (or ex_req_i), else IDLE. lock_cnt clears.
  - When lock_cnt reaches LOCK_MAX-1 and int_lock_i is still 1:
    - lock_err_o pulses the next cycle and inhibit is set;
    - next state is EX_SLOT (or IDLE if no ex request is pending).
- EX_SLOT:
  - ex_gnt_o=ex_req_i; int_gnt_o=int_req_i & ~ex_req_i.
  - Next state IDLE; ex_blocked clears.
  - A lock request in EX_SLOT is not honoured (no direct EX_SLOT->INT_LOCK).
- inhibit:
  - Blocks entry to INT_LOCK; int requests are still granted single-cycle.
  - Clears on the first cycle int_lock_i=0.
- Simultaneous ex+int in IDLE: int wins; ex stalls (stall_o=1).
- Reset mid-lock: immediate return to IDLE. No write is issued while rst_n_i=0 unless a request is asserted; the csr_reg is itself under reset.
- lock_cnt width: $clog2(LOCK_MAX)+1. Saturates at LOCK_MAX; no wrap.

Test Plan:
- Reset, then ex write req (addr 0x300, wdata 0x8) in IDLE -> same-cycle ex_gnt_o=1, csr_we_o=1, csr_waddr_o=0x300, csr_wdata_o=0x8, stall_o=0.
- Simultaneous ex read 0x341 and int write 0x341 = 0x1000 -> int_gnt_o=1, csr_wdata_o=0x1000, stall_o=1. Ex is granted the next cycle and reads 0x1000.
- Clint lock burst of 3 writes (0x341, 0x342, 0x300) with ex_req_i held high:
  - ex_gnt_o=0 for 3 cycles;
  - the lock drops, EX_SLOT grants ex on cycle 4 even though int_req_i=1 again;
  - int is granted on cycle 5.
- Lock held 16 cycles (LOCK_MAX=16):
  - lock_err_o pulses once on cycle 16, state leaves INT_LOCK, ex is granted;
  - further int_lock_i=1 gets single-cycle grants only until int_lock_i drops.
- Assert rst_n_i=0 mid-lock (cycle 2 of burst) -> state IDLE, lock_cnt=0. After release, ex_req alone is granted immediately.
- No requests for 10 cycles -> all grants 0, csr_we_o=0, csr_*=0, rdata outputs 0.
